uart_tx_core: RTL and testbench

- 8N1 UART transmitter. Downstream of the RTC-to-ASCII formatter; consumes its txEn/data byte stream and returns the busy/done handshake.
- Drives the serial line to the host terminal. One byte per request, LSB first.
- Runs entirely in the system clock domain, with an internal baud-tick counter.

---
 rtl/uart_tx_core.sv | 155 +++++++++++++++
 tb/tb_uart_tx_core.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_core.sv
// 8N1 UART transmitter with an internal baud counter; one byte per txEn request, LSB first.
// Define UART_TX_PARITY_EN to insert a parity bit (PARITY_ODD selects odd parity) between data and stop.
module uart_tx_core #(
  parameter int CLK_FREQ     = 100000000,
  parameter int BAUD         = 9600,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
`ifdef UART_TX_PARITY_EN
  ,
  parameter bit PARITY_ODD   = 1'b0
`endif
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       txEn,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  generate
    if (CLKS_PER_BIT < 4) begin : g_cpb_check
      $error("uart_tx_core: CLKS_PER_BIT must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic [7:0]       shift_nxt;
  logic             bit_end;
  logic             accept;
  logic             tx_d;
  logic             busy_d;
  logic             done_d;
`ifdef UART_TX_PARITY_EN
  logic             parity_bit;
`endif

  assign bit_end = (baud_cnt == CNT_MAX);
  assign accept  = (state == IDLE) && txEn;

  // State register plus the registered outputs, which are decoded from next_state
  // so that they line up with the state they describe.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= IDLE;
      tx    <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      tx    <= tx_d;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (txEn) next_state = START;
      START: if (bit_end) next_state = DATA;
      DATA: begin
        if (bit_end && (bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          next_state = PARITY;
`else
          next_state = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) next_state = STOP;
`endif
      STOP:  if (bit_end) next_state = DONE;
      DONE:  next_state = IDLE;  // txEn deliberately ignored: upstream still shows the old byte here
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    shift_nxt = shift;
    if (accept) begin
      shift_nxt = data;
    end else if ((state == DATA) && bit_end) begin
      shift_nxt = {1'b0, shift[7:1]};
    end
  end

  always_comb begin
    tx_d   = 1'b1;
    busy_d = (next_state != IDLE);
    done_d = (next_state == DONE);
    unique case (next_state)
      START:  tx_d = 1'b0;
      DATA:   tx_d = shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_d = parity_bit;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  // Baud counter, bit index and shift register; the counter wraps exactly at each bit boundary.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      shift <= shift_nxt;
      unique case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
        end
        DONE: baud_cnt <= '0;
        default: begin
          baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
          if ((state == DATA) && bit_end) bit_idx <= bit_idx + 3'd1;
        end
      endcase
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      parity_bit <= 1'b0;
    end else if (accept) begin
      parity_bit <= (^data) ^ PARITY_ODD;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core at 10 clocks per bit: frame vectors, held-request stepping,
// mid-frame input changes, asynchronous reset mid-frame and a long idle line.
module tb_uart_tx_core;
  localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk;
  logic       rstN;
  logic       txEn;
  logic [7:0] data;
  logic       tx;
  logic       busy;
  logic       done;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  uart_tx_core #(
    .CLK_FREQ(1000000),
    .BAUD    (100000)
  ) dut (
    .clk  (clk),
    .rstN (rstN),
    .txEn (txEn),
    .data (data),
    .tx   (tx),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0] d;
    logic [9:0] bits;  // bit i = i-th bit on the line (start, d0..d7, stop)
    logic       par;   // even parity of d
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [9:0] bits, input logic par, input int idx);
    if (NB == 11 && idx == 9) return par;
    if (idx == NB - 1) return 1'b1;
    return bits[idx[3:0]];
  endfunction

  // Sends one byte and checks every clock of the frame, the done cycle and the cycle after.
  // drop_at >= 0 keeps txEn high until that frame clock, then drops it and changes data.
  task automatic run_frame(input logic [7:0] d, input logic [9:0] bits, input logic par,
                           input int drop_at, input string name);
    int bad_tx = 0;
    int bad_ctl = 0;
    @(negedge clk);
    data = d;
    txEn = 1'b1;
    @(posedge clk);
    #1;
    if (drop_at < 0) txEn = 1'b0;
    for (int k = 0; k < NB * CPB; k++) begin
      @(negedge clk);
      if (tx !== exp_bit(bits, par, k / CPB)) bad_tx++;
      if (busy !== 1'b1 || done !== 1'b0) bad_ctl++;
      if (k == drop_at) begin
        data = 8'hFF;
        txEn = 1'b0;
      end
    end
    check({name, "_bits"}, bad_tx, 0);
    check({name, "_ctl"}, bad_ctl, 0);
    @(negedge clk);
    check({name, "_done"}, {tx, busy, done}, 3'b111);
    @(negedge clk);
    check({name, "_after"}, {tx, busy, done}, 3'b100);
  endtask

  // Waits (bounded) for a start bit, samples mid-bit, then waits (bounded) for done.
  task automatic recv_frame(output logic [7:0] b, output int t_start, output bit got_done);
    bit seen = 0;
    b = 8'h00;
    t_start = 0;
    got_done = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (tx === 1'b0) seen = 1;
    end
    check("rx_start_seen", seen, 1);
    if (!seen) return;
    t_start = cyc;
    repeat (4) @(negedge clk);
    check("rx_start_level", tx, 0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = tx;
    end
    repeat (CPB * (NB - 9)) @(negedge clk);
    check("rx_stop_level", tx, 1);
    for (int i = 0; i < 3 * CPB && !got_done; i++) begin
      @(negedge clk);
      if (done === 1'b1) got_done = 1;
    end
  endtask

  initial begin
    logic [7:0] seq [3];
    logic [7:0] rx_b;
    int         t_prev;
    int         t_now;
    bit         got;
    int         bad;

    vecs[0] = '{d: 8'h55, bits: 10'h2AA, par: 1'b0};
    vecs[1] = '{d: 8'h00, bits: 10'h200, par: 1'b0};
    vecs[2] = '{d: 8'hFF, bits: 10'h3FE, par: 1'b0};
    vecs[3] = '{d: 8'hA3, bits: 10'h346, par: 1'b0};
    vecs[4] = '{d: 8'h31, bits: 10'h262, par: 1'b1};
    vecs[5] = '{d: 8'h80, bits: 10'h300, par: 1'b1};
    vecs[6] = '{d: 8'h01, bits: 10'h202, par: 1'b1};
    vecs[7] = '{d: 8'h07, bits: 10'h20E, par: 1'b1};

    rstN = 1'b1;
    txEn = 1'b0;
    data = 8'h00;
    #2 rstN = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", {tx, busy, done}, 3'b100);
    rstN = 1'b1;

    // Idle line
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if ({tx, busy, done} !== 3'b100) bad++;
    end
    check("idle_line", bad, 0);

    // Frame vectors, one-cycle txEn pulse each
    for (int v = 0; v < 8; v++)
      run_frame(vecs[v].d, vecs[v].bits, vecs[v].par, -1, $sformatf("vec%0d", v));

    // Data and txEn changed during data bit 3: frame keeps 0x55, no second frame
    run_frame(8'h55, 10'h2AA, 1'b0, 4 * CPB + 3, "midchg");
    bad = 0;
    for (int i = 0; i < 3 * NB * CPB; i++) begin
      @(negedge clk);
      if ({tx, busy, done} !== 3'b100) bad++;
    end
    check("midchg_no_second", bad, 0);

    // Held request, upstream advances data on done
    seq[0] = 8'h31;
    seq[1] = 8'h32;
    seq[2] = 8'h0A;
    t_prev = 0;
    @(negedge clk);
    data = seq[0];
    txEn = 1'b1;
    for (int f = 0; f < 3; f++) begin
      recv_frame(rx_b, t_now, got);
      check($sformatf("held_byte%0d", f), rx_b, seq[f]);
      check($sformatf("held_done%0d", f), got, 1);
      if (f > 0) check($sformatf("held_period%0d", f), t_now - t_prev, NB * CPB + 2);
      t_prev = t_now;
      if (f < 2) data = seq[f + 1];
      else txEn = 1'b0;
    end
    bad = 0;
    for (int i = 0; i < 3 * NB * CPB; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || done !== 1'b0) bad++;
    end
    check("held_no_fourth", bad, 0);

    // Asynchronous reset during data bit 5 of 0xA3
    @(negedge clk);
    data = 8'hA3;
    txEn = 1'b1;
    @(posedge clk);
    #1;
    txEn = 1'b0;
    repeat (6 * CPB + 3) @(negedge clk);
    check("rst_mid_busy_before", busy, 1);
    #2 rstN = 1'b0;
    #1;
    check("rst_mid_async", {tx, busy, done}, 3'b100);
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ({tx, busy, done} !== 3'b100) bad++;
    end
    check("rst_mid_after", bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
